fc_dot_seq: RTL

Sequential dot-product engine for the fc_layer datapath. It accepts K operand pairs (A,B) over a valid/ready stream and feeds each pair, together with its running sum, into one mac_comb instance. After the K-th pair it presents the L-bit neuron pre-activation on a valid/ready output. It sits directly upstream of, and wraps, mac_comb: it supplies A, B and S0, and registers S.

---
 rtl/fc_pkg.sv | 15 +
 rtl/mac_comb.sv | 19 +
 rtl/fc_dot_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fc_layer datapath.
package fc_pkg;

  typedef enum logic {ACC, OUT} state_e;

  // Default accumulator width: full product plus growth for K additions.
  function automatic int default_l(input int n, input int k);
    return 2 * n + k - 1;
  endfunction

  function automatic int cnt_w(input int k);
    return (k <= 1) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/mac_comb.sv
// Combinational multiply-accumulate: S = S0 + A*B, signed, truncated to L bits.
module mac_comb #(
  parameter int N = 8,
  parameter int L = 18
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [L-1:0] S0,
  output logic [L-1:0] S
);

  logic signed [2*N-1:0] prod;
  logic signed [L-1:0]   prod_ext;

  assign prod     = $signed(A) * $signed(B);
  assign prod_ext = L'(prod);
  assign S        = S0 + prod_ext;

endmodule

// File: rtl/fc_dot_seq.sv
// Sequential K-element dot product over valid/ready streams, one mac_comb per pair.
module fc_dot_seq
  import fc_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 3,
  parameter int L = default_l(N, K)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [L-1:0] bias,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [L-1:0] out_s
);

  localparam int CW = cnt_w(K);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [L-1:0]  acc_q, acc_d;
  logic [L-1:0]  mac_s0, mac_s;

  // Element 0 starts from bias, so acc never needs clearing between vectors.
  assign mac_s0 = (cnt_q == '0) ? bias : acc_q;

  mac_comb #(
    .N(N),
    .L(L)
  ) u_mac (
    .A (in_a),
    .B (in_b),
    .S0(mac_s0),
    .S (mac_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = mac_s;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign out_s     = acc_q;

endmodule
